// File: rtl/matvec_stream_ctrl.sv
// -----------------------------------------------------------------------------
// matvec_stream_ctrl
//
// Sequencing controller for a pipelined matrix-vector multiplier
// (y[r] = sum_c k[r][c] * x[c]). The multiplier itself lives outside this
// block. This block:
//   - wraps the multiplier in valid/ready streams, with a per-vector last tag;
//   - freezes the whole pipe (mac_cen low) when the output is back-pressured;
//   - gates mac_cen when nothing is in flight;
//   - owns the weight register and only lets it change once every in-flight
//     vector has left the pipe.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_x/s_last
//              input vector stream; element c at s_x[c*W_X +: W_X]
//   k_valid/k_ready/k_in
//              weight reload request; k_ready pulses for one cycle when k_in
//              is captured. k_in is [r][c] packed row-major
//   mac_cen/mac_x/mac_k/mac_y
//              multiplier interface: clock enable, vector, weights and result
//   m_valid/m_ready/m_y/m_last
//              result stream (m_y is mac_y passed straight through)
//   busy       controller not idle, or a vector is still in the pipe
// -----------------------------------------------------------------------------
module matvec_stream_ctrl #(
    parameter int R   = 2,
    parameter int C   = 2,
    parameter int W_X = 3,
    parameter int W_K = 3,
    parameter int LAT = $clog2(C) + 1,
    parameter int W_Y = W_X + W_K + $clog2(C)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [C*W_X-1:0]     s_x,
    input  logic                 s_last,

    input  logic                 k_valid,
    output logic                 k_ready,
    input  logic [R*C*W_K-1:0]   k_in,

    output logic                 mac_cen,
    output logic [C*W_X-1:0]     mac_x,
    output logic [R*C*W_K-1:0]   mac_k,
    input  logic [R*W_Y-1:0]     mac_y,

    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [R*W_Y-1:0]     m_y,
    output logic                 m_last,

    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LAT-1:0]       vld_q, vld_d;
    logic [LAT-1:0]       lst_q, lst_d;
    logic [R*C*W_K-1:0]   mac_k_q, mac_k_d;
    logic                 k_ready_q, k_ready_d;
    logic                 busy_q, busy_d;

    logic                 stall;
    logic                 accept;
    logic                 in_flight;
    logic                 accepting_state;

    // -------------------------------------------------------------------------
    // Handshake and clock-enable logic
    // -------------------------------------------------------------------------
    // A result that cannot leave blocks every stage behind it, so the whole
    // pipe stops together; the multiplier then holds mac_y stable for us.
    assign stall           = vld_q[LAT-1] & ~m_ready;
    assign accepting_state = (state_q == ST_IDLE) | (state_q == ST_RUN);

    // A pending reload wins over a new vector in the very cycle it appears, so
    // nothing new enters the pipe once a drain has been requested.
    assign s_ready   = ~stall & accepting_state & ~k_valid;
    assign accept    = s_valid & s_ready;
    assign in_flight = |vld_q;

    // Only clock the multiplier when there is something to move.
    assign mac_cen   = ~stall & (in_flight | accept);

    // -------------------------------------------------------------------------
    // Valid / last shadow of the multiplier stages
    // -------------------------------------------------------------------------
    // Stage 0 captures the handshake of the current cycle. A bubble enters as
    // vld=0; its lst bit is a don't-care since it is never presented as valid.
    assign vld_d[0] = mac_cen ? accept : vld_q[0];
    assign lst_d[0] = mac_cen ? s_last : lst_q[0];

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
            assign vld_d[gi] = mac_cen ? vld_q[gi-1] : vld_q[gi];
            assign lst_d[gi] = mac_cen ? lst_q[gi-1] : lst_q[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mac_k_d = mac_k_q;

        case (state_q)
            ST_IDLE: begin
                // s_ready is low while k_valid is high, so these cannot both
                // apply in one cycle.
                if (k_valid) begin
                    state_d = ST_DRAIN;
                end else if (accept) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (k_valid) begin
                    state_d = ST_DRAIN;
                end else if (vld_d == '0) begin
                    // Last vector just left and no new one came in.
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // Input is closed; the pipe keeps advancing via mac_cen until
                // it is empty. An already-empty pipe still spends one cycle
                // here, which keeps the reload timing uniform.
                if (vld_q == '0) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Pipe is empty, so no in-flight vector sees the new weights.
                mac_k_d = k_in;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status outputs are derived from the next-state values so
        // that they line up with the state they describe.
        k_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE) | (|vld_d);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // Reset drops every in-flight tag, so whatever the multiplier still holds
    // is never reported as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vld_q     <= '0;
            lst_q     <= '0;
            mac_k_q   <= '0;
            k_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            lst_q     <= lst_d;
            mac_k_q   <= mac_k_d;
            k_ready_q <= k_ready_d;
            busy_q    <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign k_ready = k_ready_q;
    assign busy    = busy_q;

    assign mac_x   = s_x;
    assign mac_k   = mac_k_q;

    assign m_valid = vld_q[LAT-1];
    assign m_last  = lst_q[LAT-1];
    assign m_y     = mac_y;

endmodule

// File: tb/tb_matvec_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matvec_stream_ctrl
//
// Drives matvec_stream_ctrl together with a behavioural pipelined multiplier.
// The expected behaviour comes from a transaction-level model: a queue of
// accepted vectors, each stamped with the count of enabled cycles at the
// moment it was accepted, plus the weights the bench believes are loaded.
// Directed scenarios cover the listed cases; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_matvec_stream_ctrl;

    localparam int R   = 2;
    localparam int C   = 2;
    localparam int W_X = 3;
    localparam int W_K = 3;
    localparam int LAT = $clog2(C) + 1;
    localparam int W_Y = W_X + W_K + $clog2(C);
    localparam int WXV = C * W_X;
    localparam int WKM = R * C * W_K;
    localparam int WYV = R * W_Y;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [WXV-1:0]  s_x = '0;
    logic            s_last = 1'b0;
    logic            k_valid = 1'b0;
    logic            k_ready;
    logic [WKM-1:0]  k_in = '0;
    logic            mac_cen;
    logic [WXV-1:0]  mac_x;
    logic [WKM-1:0]  mac_k;
    logic [WYV-1:0]  mac_y;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [WYV-1:0]  m_y;
    logic            m_last;
    logic            busy;

    always #5 clk = ~clk;

    matvec_stream_ctrl #(
        .R(R), .C(C), .W_X(W_X), .W_K(W_K), .LAT(LAT), .W_Y(W_Y)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_last(s_last),
        .k_valid(k_valid), .k_ready(k_ready), .k_in(k_in),
        .mac_cen(mac_cen), .mac_x(mac_x), .mac_k(mac_k), .mac_y(mac_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_last(m_last),
        .busy(busy)
    );

    // y[r] = sum_c k[r][c] * x[c], signed, truncated to W_Y (never overflows)
    function automatic logic [WYV-1:0] matvec(input logic [WXV-1:0] x,
                                              input logic [WKM-1:0] k);
        logic [WYV-1:0] y;
        int acc, kv, xv;
        y = '0;
        for (int r = 0; r < R; r++) begin
            acc = 0;
            for (int c = 0; c < C; c++) begin
                kv = $signed(k[(r*C+c)*W_K +: W_K]);
                xv = $signed(x[c*W_X +: W_X]);
                acc += kv * xv;
            end
            y[r*W_Y +: W_Y] = acc[W_Y-1:0];
        end
        return y;
    endfunction

    // Behavioural multiplier: LAT stages, advancing only on mac_cen, no reset.
    logic [WYV-1:0] mul_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) mul_pipe[i] = '0;
    always @(posedge clk) begin
        if (mac_cen) begin
            mul_pipe[0] <= matvec(mac_x, mac_k);
            for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign mac_y = mul_pipe[LAT-1];

    function automatic logic [WXV-1:0] px(input int x0, input int x1);
        logic [WXV-1:0] v;
        v[0 +: W_X]   = x0[W_X-1:0];
        v[W_X +: W_X] = x1[W_X-1:0];
        return v;
    endfunction

    function automatic logic [WYV-1:0] py(input int y0, input int y1);
        logic [WYV-1:0] v;
        v[0 +: W_Y]   = y0[W_Y-1:0];
        v[W_Y +: W_Y] = y1[W_Y-1:0];
        return v;
    endfunction

    function automatic logic [WKM-1:0] pk(input int k00, input int k01,
                                          input int k10, input int k11);
        logic [WKM-1:0] v;
        v[0*W_K +: W_K] = k00[W_K-1:0];
        v[1*W_K +: W_K] = k01[W_K-1:0];
        v[2*W_K +: W_K] = k10[W_K-1:0];
        v[3*W_K +: W_K] = k11[W_K-1:0];
        return v;
    endfunction

    typedef struct { logic [WXV-1:0] x; logic last; } stim_t;
    typedef struct { logic [WYV-1:0] y; logic last; int stamp; } exp_t;
    typedef struct { logic [WYV-1:0] y; logic last; } out_t;

    stim_t stim_q[$];
    exp_t  sb[$];
    out_t  out_log[$];

    int             n_checks = 0;
    int             n_errors = 0;
    int             cen_count = 0;
    int             kphase = 0;      // 0 none, 1 draining, 2 weights captured this cycle
    logic [WKM-1:0] model_k = '0;
    logic           k_req = 1'b0;
    logic [WKM-1:0] k_pend = '0;
    int             v_prob = 100;
    int             r_prob = 100;
    int             seg_cyc = 0;
    int             stall_lo = -1;
    int             stall_hi = -1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle();
        logic head_valid, e_stall, e_sready, e_acc, e_cen, pre_empty;
        exp_t e;

        s_valid = (stim_q.size() != 0) && ($urandom_range(0, 99) < v_prob);
        if (stim_q.size() != 0) begin
            s_x    = stim_q[0].x;
            s_last = stim_q[0].last;
        end else begin
            s_x    = WXV'($urandom);
            s_last = 1'($urandom);
        end
        if (seg_cyc >= stall_lo && seg_cyc < stall_hi) m_ready = 1'b0;
        else m_ready = ($urandom_range(0, 99) < r_prob);
        k_valid = k_req;
        k_in    = k_req ? k_pend : WKM'($urandom);

        @(negedge clk);
        head_valid = (sb.size() != 0) && (cen_count - sb[0].stamp == LAT - 1);
        e_stall    = head_valid & ~m_ready;
        e_sready   = ~e_stall & ~k_valid;
        e_acc      = s_valid & e_sready;
        e_cen      = ~e_stall & ((sb.size() != 0) | e_acc);

        check_val("s_ready", s_ready, e_sready);
        check_val("mac_cen", mac_cen, e_cen);
        check_val("m_valid", m_valid, head_valid);
        check_val("k_ready", k_ready, kphase == 2);
        check_val("busy", busy, (sb.size() != 0) || (kphase != 0));
        check_val("mac_x", mac_x, s_x);
        check_val("mac_k", mac_k, model_k);
        if (head_valid) begin
            check_val("m_y", m_y, sb[0].y);
            check_val("m_last", m_last, sb[0].last);
        end
        if (head_valid && m_ready)
            $display("out y0=%0d y1=%0d last=%0b", $signed(m_y[0 +: W_Y]),
                     $signed(m_y[W_Y +: W_Y]), m_last);

        pre_empty = (sb.size() == 0);
        @(posedge clk);
        if (e_cen) cen_count++;
        if (head_valid && m_ready) begin
            out_log.push_back('{y: sb[0].y, last: sb[0].last});
            void'(sb.pop_front());
        end
        if (e_acc) begin
            e.y = matvec(stim_q[0].x, model_k);
            e.last = stim_q[0].last;
            e.stamp = cen_count;
            sb.push_back(e);
            void'(stim_q.pop_front());
        end
        case (kphase)
            0: if (k_valid) kphase = 1;
            1: if (pre_empty) kphase = 2;
            default: begin
                model_k = k_in;
                k_req   = 1'b0;
                kphase  = 0;
            end
        endcase
        seg_cyc++;
        #1;
    endtask

    task automatic run_drain(input int limit);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || sb.size() != 0 || k_req) && n < limit) begin
            cycle();
            n++;
        end
        check_val("drain_done", (stim_q.size() == 0 && sb.size() == 0 && !k_req), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; k_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_s_ready", s_ready, 1);
        check_val("rst_k_ready", k_ready, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_last", m_last, 0);
        check_val("rst_mac_cen", mac_cen, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_mac_k", mac_k, 0);
        sb.delete(); stim_q.delete();
        k_req = 1'b0; kphase = 0; model_k = '0; cen_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_x(input int x0, input int x1, input logic last);
        stim_q.push_back('{x: px(x0, x1), last: last});
    endtask

    initial begin
        int idle_bad;

        // Reset, then load [[1,2],[3,-1]] and send one vector
        do_reset();
        k_pend = pk(1, 2, 3, -1); k_req = 1'b1;
        run_drain(20);
        check_val("k_loaded", mac_k, pk(1, 2, 3, -1));
        out_log.delete();
        push_x(2, 1, 1'b0);
        run_drain(20);
        check_val("single_cnt", out_log.size(), 1);
        if (out_log.size() == 1) check_val("single_y", out_log[0].y, py(4, 5));

        // Back-to-back with m_ready=1
        out_log.delete();
        push_x(2, 1, 1'b0); push_x(-4, 3, 1'b0); push_x(1, 1, 1'b1);
        run_drain(20);
        check_val("b2b_cnt", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_val("b2b_y0", out_log[0].y, py(4, 5));
            check_val("b2b_y1", out_log[1].y, py(2, -15));
            check_val("b2b_y2", out_log[2].y, py(3, 2));
            check_val("b2b_last", {out_log[0].last, out_log[1].last, out_log[2].last}, 3'b001);
        end

        // Same stream, three stalled cycles from the first m_valid
        out_log.delete();
        push_x(2, 1, 1'b0); push_x(-4, 3, 1'b0); push_x(1, 1, 1'b1);
        seg_cyc = 0; stall_lo = 2; stall_hi = 5;
        run_drain(30);
        stall_lo = -1; stall_hi = -1;
        check_val("stall_cnt", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_val("stall_y0", out_log[0].y, py(4, 5));
            check_val("stall_y1", out_log[1].y, py(2, -15));
            check_val("stall_y2", out_log[2].y, py(3, 2));
        end

        // Reload while two vectors are in flight
        out_log.delete();
        push_x(2, 1, 1'b0); push_x(-4, 3, 1'b1);
        cycle(); cycle();
        k_pend = pk(-1, 0, 0, 1); k_req = 1'b1;
        run_drain(30);
        check_val("reload_cnt", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check_val("reload_old0", out_log[0].y, py(4, 5));
            check_val("reload_old1", out_log[1].y, py(2, -15));
        end
        out_log.delete();
        push_x(2, 1, 1'b1);
        run_drain(20);
        if (out_log.size() == 1) check_val("reload_new", out_log[0].y, py(-2, 1));
        else check_val("reload_new_cnt", out_log.size(), 1);

        // Idle for 10 cycles
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (mac_cen || busy) idle_bad++;
        end
        check_val("idle_quiet", idle_bad, 0);

        // Reset with the pipe full and stalled
        push_x(1, 2, 1'b0); push_x(3, -2, 1'b0); push_x(-1, -1, 1'b1);
        r_prob = 0;
        for (int i = 0; i < 4; i++) cycle();
        r_prob = 100;
        do_reset();
        out_log.delete();
        push_x(3, 3, 1'b1);
        run_drain(20);
        if (out_log.size() == 1) check_val("post_rst_y", out_log[0].y, py(0, 0));
        else check_val("post_rst_cnt", out_log.size(), 1);

        // Randomized traffic with occasional reloads and back-pressure
        v_prob = 70; r_prob = 65;
        for (int i = 0; i < 400; i++) begin
            if (stim_q.size() < 4)
                stim_q.push_back('{x: WXV'($urandom), last: 1'($urandom)});
            if (!k_req && $urandom_range(0, 39) == 0) begin
                k_pend = WKM'($urandom);
                k_req  = 1'b1;
            end
            cycle();
        end
        run_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit in case a wait above is broken
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matvec_stream_ctrl.md
Name: matvec_stream_ctrl

Overview:
- Sequencing controller for the pipelined matrix-vector multiplier: drives its `cen`, presents `x`, and owns the weight matrix `k` register.
- Wraps the multiplier in valid/ready streams with a per-vector `last` tag and full-pipeline back-pressure stall.
- Gates `cen` when the pipeline is empty.
- Serialises weight reloads: drains in-flight vectors before `k` changes.

Parameters:
- R, 2, matrix rows (output vector length)
- C, 2, matrix columns (input vector length)
- W_X, 3, signed input element width
- W_K, 3, signed weight element width
- LAT, $clog2(C)+1, multiplier pipeline depth in cen-enabled cycles; must equal the multiplier's
- W_Y, W_X+W_K+$clog2(C), output element width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input vector valid
- s_ready  out  1  controller accepts input vector
- s_x  in  C*W_X  input vector, element c at [c*W_X +: W_X]
- s_last  in  1  last vector of frame
- k_valid  in  1  weight reload request; held until accepted
- k_ready  out  1  weight reload accepted this cycle
- k_in  in  R*C*W_K  new weights, [r][c] packed row-major
- mac_cen  out  1  clock enable to multiplier
- mac_x  out  C*W_X  vector to multiplier
- mac_k  out  R*C*W_K  registered weights to multiplier
- mac_y  in  R*W_Y  multiplier result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_y  out  R*W_Y  result vector (= mac_y)
- m_last  out  1  last tag aligned with m_y
- busy  out  1  state != IDLE or any vector in flight

Behaviour:
- Tracking: LAT-bit valid shift register `vld` and LAT-bit `lst` shadow the multiplier stages; both shift only when mac_cen=1.
  - vld[0] <= s_valid & s_ready; lst[0] <= s_last.
  - m_valid = vld[LAT-1]; m_last = lst[LAT-1]; m_y = mac_y.
- Stall: stall = m_valid & ~m_ready.
  - mac_cen = ~stall & (|vld | (s_valid & s_ready)).
  - A stall freezes the whole pipe; m_y and m_last hold stable while m_valid=1 and m_ready=0.
- s_ready = ~stall & (state==IDLE | state==RUN) & ~k_valid. A k_valid request blocks input in the same cycle it rises (k wins a tie).
- mac_x = s_x (combinational). Bubbles (vld[0]=0) may carry any x value.
- Latency: a vector accepted at edge t gives m_valid=1 in the cycle after edge t+LAT-1 (LAT edges after acceptance) when no stall. Throughput is 1 vector/cycle.
- FSM:
  - IDLE: goes to RUN on accept; goes to DRAIN on k_valid.
  - RUN: goes to IDLE when vld becomes all-zero with no accept; goes to DRAIN on k_valid.
  - DRAIN: no accepts; the pipe advances until vld==0, then goes to LOAD.
  - LOAD: k_ready=1 for exactly one cycle; mac_k <= k_in at that edge; then goes to IDLE.
  - k_valid asserted while already in IDLE with vld==0 still passes through DRAIN (1 cycle) and then LOAD.
- Reset (also mid-operation):
  - State → IDLE; vld and lst → 0; mac_k → 0.
  - Outputs: s_ready=1, k_ready=0, m_valid=0, m_last=0, mac_cen=0, busy=0.
  - In-flight results are discarded; stale mac_y contents are never flagged valid.
- Arithmetic is done entirely in the multiplier; the controller performs no width changes.
- Per-row result: y[r] = Σc k[r][c]·x[c], signed, full precision W_Y, no saturation.
- s_valid deasserting mid-frame inserts bubbles; the order of m_last tags is preserved.

Test Plan:
- R=2,C=2 (LAT=2); reset; k load [[1,2],[3,-1]]; send x=[2,1] → k_ready pulses once; 2 edges after acceptance m_valid=1, y=[4,5].
- Back-to-back x=[2,1],[-4,3],[1,1] with m_ready=1 → three consecutive m_valid cycles, y=[4,5],[2,-15],[3,2]; last asserted on third only.
- Same stream with m_ready=0 for 3 cycles after first m_valid → s_ready=0 and mac_cen=0 during stall; y=[4,5] held; no loss or duplication after release.
- k_valid raised while 2 vectors are in flight with new k=[[-1,0],[0,1]] → s_ready drops the same cycle; both old results emerge with old k; k_ready pulses after drain; next x=[2,1] gives y=[-2,1].
- Idle for 10 cycles → mac_cen=0, busy=0 throughout.
- rst asserted with the pipe full → next cycle m_valid=0, vld cleared, mac_k=0; a subsequent x=[3,3] gives y=[0,0].
